// File: rtl/serial_word_assembler.sv
// Serial-to-parallel word assembler: LSB-first bits into N-bit words, double-buffered
// behind a valid/ready output register. Define SERIAL_WORD_ASSEMBLER_PARITY_EN for an even-parity trailer bit.
module serial_word_assembler #(
  parameter int N     = 4,
  parameter int CNT_W = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         si,
  input  logic         si_valid,
  input  logic         flush,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         overrun,
  output logic         parity_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N-1);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(N);
`endif

  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]   sh_q, sh_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           overrun_q, overrun_d;
  logic [N-1:0]   sh_shift;
  logic [N-1:0]   word;
  logic           complete;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  logic           parity_err_q, parity_err_d;
  logic           word_perr;
`endif

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  assign sh_shift = {si, sh_q[N-1:1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    complete = 1'b0;
    word     = sh_shift;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    word_perr = 1'b0;
`endif
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (si_valid) begin
            sh_d    = sh_shift;
            cnt_d   = CNT_W'(1);
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          if (si_valid) begin
            sh_d = sh_shift;
            if (cnt_q == LAST_CNT) begin
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
              cnt_d   = FULL_CNT;
              state_d = PARITY;
`else
              complete = 1'b1;
              cnt_d    = '0;
              state_d  = IDLE;
`endif
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        PARITY: begin
          if (si_valid) begin
            complete  = 1'b1;
            word      = sh_q;
            word_perr = (^sh_q) ^ si;
            cnt_d     = '0;
            state_d   = IDLE;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output holding register: a completed word is taken if the slot is free or
  // being emptied this cycle; otherwise it is dropped and flagged.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (complete) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = word;
        out_valid_d = 1'b1;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
        parity_err_d = word_perr;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_assembler.sv
// Directed self-checking bench for serial_word_assembler (N=4); parity cases
// run only when SERIAL_WORD_ASSEMBLER_PARITY_EN is defined.
module tb_serial_word_assembler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         si;
  logic         si_valid;
  logic         flush;
  logic [N-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int tests_run = 0;
  int tests_failed = 0;

  serial_word_assembler #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .si        (si),
    .si_valid  (si_valid),
    .flush     (flush),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .overrun   (overrun),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    si       = b;
    si_valid = 1'b1;
    tick();
    si_valid = 1'b0;
    si       = 1'b0;
  endtask

  // Completes a frame whose data bits have been sent (parity trailer if enabled).
  task automatic end_frame(input logic [N-1:0] w);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    send_bit(^w);
`else
    if (w === 'x) $display("unexpected unknown word");
`endif
  endtask

  task automatic send_word(input logic [N-1:0] w);
    for (int i = 0; i < N; i++) send_bit(w[i]);
    end_frame(w);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(out_data), 32'h0);
    check({tag, "_valid"}, 32'(out_valid), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_ovr"}, 32'(overrun), 32'h0);
    check({tag, "_perr"}, 32'(parity_err), 32'h0);
  endtask

  initial begin
    logic [N-1:0] w;
    reset = 1'b1; si = 1'b0; si_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle_busy", 32'(busy), 32'h0);

    // Basic frame 1,0,1,1 -> D
    w = 4'hD;
    for (int i = 0; i < N; i++) begin
      send_bit(w[i]);
      if (i < N-1) begin
        check("basic_busy", 32'(busy), 32'h1);
        check("basic_early_valid", 32'(out_valid), 32'h0);
      end
    end
    end_frame(w);
    check("basic_data", 32'(out_data), 32'hD);
    check("basic_valid", 32'(out_valid), 32'h1);
    check("basic_busy_done", 32'(busy), 32'h0);
    tick();
    check("basic_consumed", 32'(out_valid), 32'h0);

    // Gapped bits 0,1,1,0 -> 6
    w = 4'h6;
    for (int i = 0; i < N; i++) begin
      send_bit(w[i]);
      if (i < N-1) begin
        repeat (3) tick();
        check("gap_no_valid", 32'(out_valid), 32'h0);
        check("gap_busy", 32'(busy), 32'h1);
      end
    end
    end_frame(w);
    check("gap_data", 32'(out_data), 32'h6);
    check("gap_valid", 32'(out_valid), 32'h1);
    tick();
    check("gap_consumed", 32'(out_valid), 32'h0);

    // Backpressure: D held, 2 dropped
    out_ready = 1'b0;
    send_word(4'hD);
    check("bp_first_valid", 32'(out_valid), 32'h1);
    check("bp_first_data", 32'(out_data), 32'hD);
    check("bp_no_ovr_yet", 32'(overrun), 32'h0);
    tick();
    check("bp_hold_valid", 32'(out_valid), 32'h1);
    send_word(4'h2);
    check("bp_hold_data", 32'(out_data), 32'hD);
    check("bp_ovr", 32'(overrun), 32'h1);
    check("bp_still_valid", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    check("bp_accept", 32'(out_valid), 32'h0);
    check("bp_ovr_sticky", 32'(overrun), 32'h1);

    // Simultaneous hand-over A -> 5 (after reset to clear overrun)
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    out_ready = 1'b0;
    send_word(4'hA);
    check("ho_a_data", 32'(out_data), 32'hA);
    w = 4'h5;
    send_bit(w[0]); send_bit(w[1]); send_bit(w[2]);
`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    send_bit(w[3]);
    out_ready = 1'b1;
    end_frame(w);
`else
    out_ready = 1'b1;
    send_bit(w[3]);
`endif
    check("ho_data", 32'(out_data), 32'h5);
    check("ho_valid", 32'(out_valid), 32'h1);
    check("ho_ovr", 32'(overrun), 32'h0);
    tick();
    check("ho_consumed", 32'(out_valid), 32'h0);

    // Flush after 2 bits, then 1,1,1,1 -> F
    send_bit(1'b0); send_bit(1'b0);
    flush = 1'b1; si = 1'b1; si_valid = 1'b1;
    tick();
    flush = 1'b0; si = 1'b0; si_valid = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_no_valid", 32'(out_valid), 32'h0);
    w = 4'hF;
    for (int i = 0; i < N-1; i++) send_bit(w[i]);
    check("flush_no_early", 32'(out_valid), 32'h0);
    out_ready = 1'b0;
    send_bit(w[N-1]);
    end_frame(w);
    check("flush_data", 32'(out_data), 32'hF);
    check("flush_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset mid-frame after 3 bits
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("pre_rst_busy", 32'(busy), 32'h1);
    #1 reset = 1'b1;
    #1;
    check_all_zero("async_rst");
    reset = 1'b0;
    out_ready = 1'b1;
    send_bit(1'b0);
    check("post_rst_no_early", 32'(out_valid), 32'h0);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    end_frame(4'h8);
    check("post_rst_data", 32'(out_data), 32'h8);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    tick();

`ifdef SERIAL_WORD_ASSEMBLER_PARITY_EN
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check("par_wait_busy", 32'(busy), 32'h1);
    send_bit(1'b0);
    check("par_ok_data", 32'(out_data), 32'h3);
    check("par_ok_err", 32'(parity_err), 32'h0);
    tick();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0);
    check("par_bad_data", 32'(out_data), 32'h1);
    check("par_bad_err", 32'(parity_err), 32'h1);
    tick();
`else
    check("perr_tied", 32'(parity_err), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
